nec_ir_decoder: RTL and testbench

Parametrised successor to the team's NEC infrared receiver. It decodes the full 32-bit NEC frame: standard and extended address, command with checksum, and repeat codes. It adds an input glitch filter, a repeat validity window and classified error reporting. It runs on a single clock using a tick enable, with no derived clock, and sits between the IR receiver pin and the game-control logic.

---
 rtl/nec_ir_decoder_if.sv | 32 +++
 rtl/nec_ir_decoder.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_nec_ir_decoder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nec_ir_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : nec_ir_decoder_if
// Description : Decoded-result bundle produced by the NEC IR decoder.
//               master = decoder side (drives), slave = game-control side.
//   frame_valid  : one-cycle pulse, new frame decoded and checked
//   repeat_valid : one-cycle pulse, accepted repeat code
//   addr         : decoded address (held)
//   ext_addr     : 1 = extended 16-bit address frame (held)
//   cmd          : decoded command (held)
//   err          : one-cycle pulse, frame or repeat rejected
//   err_code     : rejection cause, valid with err, held until next err
// Revision    : 1.0 - initial release
// ============================================================================
interface nec_ir_decoder_if;
    logic        frame_valid;
    logic        repeat_valid;
    logic [15:0] addr;
    logic        ext_addr;
    logic [7:0]  cmd;
    logic        err;
    logic [2:0]  err_code;

    modport master (
        output frame_valid, repeat_valid, addr, ext_addr, cmd, err, err_code
    );

    modport slave (
        input frame_valid, repeat_valid, addr, ext_addr, cmd, err, err_code
    );
endinterface
`default_nettype wire

// File: rtl/nec_ir_decoder.sv
`default_nettype none
// ============================================================================
// Module      : nec_ir_decoder
// Description : NEC infrared frame decoder with glitch filter, repeat-code
//               validity window and classified error reporting. Single clock,
//               all protocol timing runs on a 125 us tick enable.
//   sys_clk   : system clock
//   sys_rst   : synchronous active-high reset
//   remote_in : raw IR receiver output (asynchronous)
//   dec_if    : decoded-result bundle (master side)
// Error codes : 1 lead mark width, 2 lead space width, 3 bit/repeat width,
//               4 command checksum, 5 repeat outside window, 6 timeout
// Revision    : 1.0 - initial release
// ============================================================================
module nec_ir_decoder #(
    parameter int TICK_CYCLES = 6250,
    parameter int FILT_LEN    = 3,
    parameter int INVERT_IN   = 0,
    parameter int REPEAT_WIN  = 880
) (
    input  wire logic         sys_clk,
    input  wire logic         sys_rst,
    input  wire logic         remote_in,
    nec_ir_decoder_if.master  dec_if
);

    localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int RWIN_W  = (REPEAT_WIN > 0) ? $clog2(REPEAT_WIN + 1) : 1;

    // Width windows in ticks (inclusive)
    localparam logic [7:0] LEAD_MARK_MIN  = 8'd69;
    localparam logic [7:0] LEAD_MARK_MAX  = 8'd75;
    localparam logic [7:0] LEAD_SPACE_MIN = 8'd33;
    localparam logic [7:0] LEAD_SPACE_MAX = 8'd38;
    localparam logic [7:0] RPT_SPACE_MIN  = 8'd15;
    localparam logic [7:0] RPT_SPACE_MAX  = 8'd20;
    localparam logic [7:0] SHORT_MIN      = 8'd2;
    localparam logic [7:0] SHORT_MAX      = 8'd6;
    localparam logic [7:0] LONG_MIN       = 8'd10;
    localparam logic [7:0] LONG_MAX       = 8'd15;

    localparam logic [2:0] E_LEAD_MARK  = 3'd1;
    localparam logic [2:0] E_LEAD_SPACE = 3'd2;
    localparam logic [2:0] E_BIT        = 3'd3;
    localparam logic [2:0] E_CHECKSUM   = 3'd4;
    localparam logic [2:0] E_RPT_CLOSED = 3'd5;
    localparam logic [2:0] E_TIMEOUT    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LEAD_MARK  = 3'd1,
        S_LEAD_SPACE = 3'd2,
        S_BIT_MARK   = 3'd3,
        S_BIT_SPACE  = 3'd4,
        S_STOP       = 3'd5,
        S_RPT_MARK   = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and tick prescaler
    // ------------------------------------------------------------------
    logic [1:0]         sync_q;
    logic [PRESC_W-1:0] presc_q;
    logic               tick;
    logic               mark;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q  <= 2'b00;
            presc_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], remote_in};
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    assign tick = (presc_q == PRESC_W'(TICK_CYCLES - 1));
    assign mark = (INVERT_IN != 0) ? sync_q[1] : ~sync_q[1];

    // ------------------------------------------------------------------
    // Glitch filter: level flips on the FILT_LEN-th consecutive
    // disagreeing tick, so rising and falling edges see the same delay.
    // ------------------------------------------------------------------
    logic       filt_q;
    logic [2:0] filt_cnt_q;
    logic       flip;
    logic       mark_rise;
    logic       mark_fall;

    assign flip      = tick && (mark != filt_q) && (filt_cnt_q == 3'(FILT_LEN - 1));
    assign mark_rise = flip && !filt_q;
    assign mark_fall = flip &&  filt_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= 3'd0;
        end else if (tick) begin
            if (mark == filt_q) begin
                filt_cnt_q <= 3'd0;
            end else if (flip) begin
                filt_q     <= ~filt_q;
                filt_cnt_q <= 3'd0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decoder FSM, width counter, repeat window and result registers
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [7:0]        width_q;
    logic [7:0]        width_inc;
    logic [5:0]        bit_cnt_q;
    logic [31:0]       shift_q;
    logic [RWIN_W-1:0] rwin_q;
    logic              rwin_open;
    logic              frame_valid_q;
    logic              repeat_valid_q;
    logic              err_q;
    logic [2:0]        err_code_q;
    logic [15:0]       addr_q;
    logic              ext_addr_q;
    logic [7:0]        cmd_q;
    logic [7:0]        b0, b1, b2, b3;

    // Width including the current tick; this is the measured edge-to-edge
    // width when an edge arrives, and the elapsed time otherwise.
    assign width_inc = (width_q == 8'hFF) ? 8'hFF : width_q + 8'd1;
    assign rwin_open = (rwin_q < RWIN_W'(REPEAT_WIN));

    assign b0 = shift_q[7:0];
    assign b1 = shift_q[15:8];
    assign b2 = shift_q[23:16];
    assign b3 = shift_q[31:24];

    function automatic logic in_win(input logic [7:0] w, input logic [7:0] lo,
                                    input logic [7:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q        <= S_IDLE;
            width_q        <= 8'd0;
            bit_cnt_q      <= 6'd0;
            shift_q        <= 32'd0;
            rwin_q         <= RWIN_W'(REPEAT_WIN);
            frame_valid_q  <= 1'b0;
            repeat_valid_q <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= 3'd0;
            addr_q         <= 16'd0;
            ext_addr_q     <= 1'b0;
            cmd_q          <= 8'd0;
        end else begin
            frame_valid_q  <= 1'b0;
            repeat_valid_q <= 1'b0;
            err_q          <= 1'b0;

            if (tick) begin
                // Edges the FSM ignores only occur in IDLE/STOP, where the
                // width is irrelevant, so clearing on every edge is safe.
                width_q <= flip ? 8'd0 : width_inc;
                if (rwin_open) begin
                    rwin_q <= rwin_q + 1'b1;
                end

                case (state_q)
                    S_IDLE: begin
                        if (mark_rise) begin
                            state_q <= S_LEAD_MARK;
                        end
                    end

                    S_LEAD_MARK: begin
                        if (mark_fall) begin
                            if (in_win(width_inc, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                                state_q <= S_LEAD_SPACE;
                            end else begin
                                err_q <= 1'b1; err_code_q <= E_LEAD_MARK; state_q <= S_IDLE;
                            end
                        end else if (width_inc > LEAD_MARK_MAX + 8'd1) begin
                            err_q <= 1'b1; err_code_q <= E_TIMEOUT; state_q <= S_IDLE;
                        end
                    end

                    S_LEAD_SPACE: begin
                        if (mark_rise) begin
                            if (in_win(width_inc, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
                                bit_cnt_q <= 6'd0;
                                state_q   <= S_BIT_MARK;
                            end else if (in_win(width_inc, RPT_SPACE_MIN, RPT_SPACE_MAX)) begin
                                state_q <= S_RPT_MARK;
                            end else begin
                                err_q <= 1'b1; err_code_q <= E_LEAD_SPACE; state_q <= S_IDLE;
                            end
                        end else if (width_inc > LEAD_SPACE_MAX + 8'd1) begin
                            err_q <= 1'b1; err_code_q <= E_TIMEOUT; state_q <= S_IDLE;
                        end
                    end

                    S_BIT_MARK: begin
                        if (mark_fall) begin
                            if (!in_win(width_inc, SHORT_MIN, SHORT_MAX)) begin
                                err_q <= 1'b1; err_code_q <= E_BIT; state_q <= S_IDLE;
                            end else if (bit_cnt_q == 6'd32) begin
                                state_q <= S_STOP;   // this was the stop mark
                            end else begin
                                state_q <= S_BIT_SPACE;
                            end
                        end else if (width_inc > SHORT_MAX + 8'd1) begin
                            err_q <= 1'b1; err_code_q <= E_TIMEOUT; state_q <= S_IDLE;
                        end
                    end

                    S_BIT_SPACE: begin
                        if (mark_rise) begin
                            if (in_win(width_inc, SHORT_MIN, SHORT_MAX) ||
                                in_win(width_inc, LONG_MIN, LONG_MAX)) begin
                                // LSB-first: first received bit ends up in bit 0
                                shift_q   <= {in_win(width_inc, LONG_MIN, LONG_MAX), shift_q[31:1]};
                                bit_cnt_q <= bit_cnt_q + 6'd1;
                                state_q   <= S_BIT_MARK;
                            end else begin
                                err_q <= 1'b1; err_code_q <= E_BIT; state_q <= S_IDLE;
                            end
                        end else if (width_inc > LONG_MAX + 8'd1) begin
                            err_q <= 1'b1; err_code_q <= E_TIMEOUT; state_q <= S_IDLE;
                        end
                    end

                    S_STOP: begin
                        state_q <= S_IDLE;
                        if (b3 != ~b2) begin
                            err_q <= 1'b1; err_code_q <= E_CHECKSUM;
                        end else begin
                            cmd_q <= b2;
                            if (b1 == ~b0) begin
                                ext_addr_q <= 1'b0;
                                addr_q     <= {8'h00, b0};
                            end else begin
                                ext_addr_q <= 1'b1;
                                addr_q     <= {b1, b0};
                            end
                            frame_valid_q <= 1'b1;
                            rwin_q        <= '0;
                        end
                    end

                    S_RPT_MARK: begin
                        if (mark_fall) begin
                            state_q <= S_IDLE;
                            if (!in_win(width_inc, SHORT_MIN, SHORT_MAX)) begin
                                err_q <= 1'b1; err_code_q <= E_BIT;
                            end else if (rwin_open) begin
                                repeat_valid_q <= 1'b1;
                                rwin_q         <= '0;
                            end else begin
                                err_q <= 1'b1; err_code_q <= E_RPT_CLOSED;
                            end
                        end else if (width_inc > SHORT_MAX + 8'd1) begin
                            err_q <= 1'b1; err_code_q <= E_TIMEOUT; state_q <= S_IDLE;
                        end
                    end

                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign dec_if.frame_valid  = frame_valid_q;
    assign dec_if.repeat_valid = repeat_valid_q;
    assign dec_if.err          = err_q;
    assign dec_if.err_code     = err_code_q;
    assign dec_if.addr         = addr_q;
    assign dec_if.ext_addr     = ext_addr_q;
    assign dec_if.cmd          = cmd_q;

endmodule
`default_nettype wire

// File: tb/tb_nec_ir_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nec_ir_decoder
// Description : Self-checking bench for nec_ir_decoder. Directed IR waveforms
//               are driven in tick units; expected decoder events are queued
//               as each waveform is sent and matched by a monitor on every
//               frame_valid / repeat_valid / err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nec_ir_decoder;

    localparam int TC = 4;      // sys_clk cycles per tick

    localparam int K_FRAME  = 0;
    localparam int K_REPEAT = 1;
    localparam int K_ERR    = 2;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic remote_in = 1'b1;

    nec_ir_decoder_if ir_if ();

    nec_ir_decoder #(
        .TICK_CYCLES (TC),
        .FILT_LEN    (3),
        .INVERT_IN   (0),
        .REPEAT_WIN  (880)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .remote_in (remote_in),
        .dec_if    (ir_if)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          kind;
        logic [2:0]  code;
        logic [15:0] addr;
        logic        ext;
        logic [7:0]  cmd;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_addr = 16'h0000;
    logic        m_ext  = 1'b0;
    logic [7:0]  m_cmd  = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- expectation helpers ----------------
    task automatic expect_frame(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3);
        exp_t e;
        if (b3 != ~b2) begin
            e = '{kind: K_ERR, code: 3'd4, addr: m_addr, ext: m_ext, cmd: m_cmd};
        end else begin
            m_cmd = b2;
            if (b1 == ~b0) begin
                m_ext  = 1'b0;
                m_addr = {8'h00, b0};
            end else begin
                m_ext  = 1'b1;
                m_addr = {b1, b0};
            end
            e = '{kind: K_FRAME, code: 3'd0, addr: m_addr, ext: m_ext, cmd: m_cmd};
        end
        sbq.push_back(e);
    endtask

    task automatic expect_err(input logic [2:0] code);
        exp_t e;
        e = '{kind: K_ERR, code: code, addr: m_addr, ext: m_ext, cmd: m_cmd};
        sbq.push_back(e);
    endtask

    task automatic expect_repeat();
        exp_t e;
        e = '{kind: K_REPEAT, code: 3'd0, addr: m_addr, ext: m_ext, cmd: m_cmd};
        sbq.push_back(e);
    endtask

    // ---------------- waveform helpers (remote_in low = mark) ----------------
    task automatic mark(input int ticks);
        remote_in = 1'b0;
        repeat (ticks * TC) @(negedge sys_clk);
    endtask

    task automatic space(input int ticks);
        remote_in = 1'b1;
        repeat (ticks * TC) @(negedge sys_clk);
    endtask

    // glitch_bit >= 0 puts a one-tick space inside that bit's mark
    task automatic send_bits(input logic [31:0] data, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch_bit) begin
                mark(3); space(1); mark(1);
            end else begin
                mark(4);
            end
            space(data[i] ? 13 : 4);
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input int glitch_bit);
        mark(72);
        space(36);
        send_bits({b3, b2, b1, b0}, 32, glitch_bit);
        mark(4);
        space(20);
    endtask

    task automatic send_repeat();
        mark(72);
        space(18);
        mark(4);
        space(20);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4000 && sbq.size() != 0; i++) @(negedge sys_clk);
        check(tag, sbq.size(), 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge sys_clk) begin
        if (!sys_rst && (ir_if.frame_valid || ir_if.repeat_valid || ir_if.err)) begin
            exp_t e;
            int   kind;
            check("pulse_onehot",
                  32'(ir_if.frame_valid) + 32'(ir_if.repeat_valid) + 32'(ir_if.err), 1);
            kind = ir_if.frame_valid ? K_FRAME : (ir_if.repeat_valid ? K_REPEAT : K_ERR);
            total++;
            assert (sbq.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_pulse: observed kind=%0d err_code=%0d expected no pulse",
                       kind, ir_if.err_code);
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("pulse_kind", kind, e.kind);
                check("addr", ir_if.addr, e.addr);
                check("ext_addr", ir_if.ext_addr, e.ext);
                check("cmd", ir_if.cmd, e.cmd);
                if (e.kind == K_ERR) check("err_code", ir_if.err_code, e.code);
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        repeat (5) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // reset state
        check("rst_frame_valid", ir_if.frame_valid, 0);
        check("rst_repeat_valid", ir_if.repeat_valid, 0);
        check("rst_err", ir_if.err, 0);
        check("rst_err_code", ir_if.err_code, 0);
        check("rst_addr", ir_if.addr, 0);
        check("rst_ext_addr", ir_if.ext_addr, 0);
        check("rst_cmd", ir_if.cmd, 0);
        space(10);

        // standard frame
        expect_frame(8'h00, 8'hFF, 8'h45, 8'hBA);
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, -1);
        drain("drain_std");

        // extended frame
        expect_frame(8'h34, 8'h12, 8'h18, 8'hE7);
        send_frame(8'h34, 8'h12, 8'h18, 8'hE7, -1);
        drain("drain_ext");

        // checksum error: outputs keep previous values
        expect_frame(8'h00, 8'hFF, 8'h45, 8'hBB);
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBB, -1);
        drain("drain_cksum");

        // short lead mark
        expect_err(3'd1);
        mark(60);
        space(40);
        drain("drain_lead");
        check("err_code_held", ir_if.err_code, 1);

        // valid frame then repeat inside the window
        expect_frame(8'h00, 8'hFF, 8'h45, 8'hBA);
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, -1);
        drain("drain_pre_rpt");
        space(200);
        expect_repeat();
        send_repeat();
        drain("drain_rpt_ok");

        // repeat after the window has closed
        space(1600);
        expect_err(3'd5);
        send_repeat();
        drain("drain_rpt_late");

        // one-tick space glitch inside a bit mark
        expect_frame(8'h0A, 8'hF5, 8'h5C, 8'hA3);
        send_frame(8'h0A, 8'hF5, 8'h5C, 8'hA3, 5);
        drain("drain_glitch");

        // line stuck at mark after the lead
        expect_err(3'd6);
        mark(72);
        space(36);
        mark(300);
        space(40);
        drain("drain_timeout");

        // reset in the middle of a frame
        mark(72);
        space(36);
        send_bits(32'h0000_1234, 17, -1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        m_addr = 16'h0000; m_ext = 1'b0; m_cmd = 8'h00;
        space(150);
        check("midrst_no_pending", sbq.size(), 0);
        check("midrst_addr", ir_if.addr, 0);
        check("midrst_cmd", ir_if.cmd, 0);
        check("midrst_err_code", ir_if.err_code, 0);

        // clean frame after the reset
        expect_frame(8'h34, 8'h12, 8'h18, 8'hE7);
        send_frame(8'h34, 8'h12, 8'h18, 8'hE7, -1);
        drain("drain_post_rst");

        space(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
